// File: rtl/alu_seq_ctrl_if.sv
// Bus between the execute-stage pipeline and the multi-cycle ALU sequencer.
// Handshake: an operation is accepted on a rising clk edge where start=1 and
// ready=1; ready is high exactly while the sequencer is idle, a start seen
// while busy is dropped (not queued), and every accepted operation produces
// exactly one single-cycle done pulse unless reset aborts it first.
interface alu_seq_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       sel;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] hi;
   logic             div_zero;
   logic [1:0]       state_dbg;

   modport master (
      output start, sel, a, b,
      input  ready, busy, done, result, hi, div_zero, state_dbg
   );

   modport slave (
      input  start, sel, a, b,
      output ready, busy, done, result, hi, div_zero, state_dbg
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: logic/add/sub/slt finish in one cycle, MUL is an
// iterative unsigned shift-add and DIV an iterative unsigned restoring divide,
// each taking WIDTH cycles while busy stalls the pipeline.
module alu_seq_ctrl #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          rst,
   alu_seq_ctrl_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [2:0] SEL_AND = 3'b001;
   localparam logic [2:0] SEL_OR  = 3'b010;
   localparam logic [2:0] SEL_SUB = 3'b011;
   localparam logic [2:0] SEL_MUL = 3'b100;
   localparam logic [2:0] SEL_DIV = 3'b101;
   localparam logic [2:0] SEL_ADD = 3'b110;
   localparam logic [2:0] SEL_SLT = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   state_t             state;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;       // MUL product accumulator
   logic [2*WIDTH-1:0] mcand;     // multiplicand, shifted left each step
   logic [WIDTH-1:0]   shreg;     // MUL: multiplier (shifts right); DIV: dividend in, quotient out
   logic [WIDTH-1:0]   divisor;
   logic [WIDTH-1:0]   rem;

   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH:0]     rem_sh;
   logic               q_bit;
   logic [WIDTH-1:0]   rem_next;
   logic [WIDTH-1:0]   quot_next;
   logic               last_iter;

   assign bus.ready     = (state == S_IDLE);
   assign bus.busy      = ~bus.ready;
   assign bus.state_dbg = state;

   // One iteration step of the multiplier and of the divider.
   always_comb begin
      acc_next  = acc;
      rem_sh    = '0;
      q_bit     = 1'b0;
      rem_next  = rem;
      quot_next = shreg;
      last_iter = (count == CW'(WIDTH - 1));
      if (shreg[0]) begin
         acc_next = acc + mcand;
      end
      // The partial remainder stays below the divisor, so the difference
      // always fits in WIDTH bits even though the compare needs WIDTH+1.
      rem_sh    = {rem, shreg[WIDTH-1]};
      q_bit     = (rem_sh >= {1'b0, divisor});
      rem_next  = q_bit ? (rem_sh[WIDTH-1:0] - divisor) : rem_sh[WIDTH-1:0];
      quot_next = {shreg[WIDTH-2:0], q_bit};
   end

   // Sequencer FSM with registered result, hi, div_zero and done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         count        <= '0;
         acc          <= '0;
         mcand        <= '0;
         shreg        <= '0;
         divisor      <= '0;
         rem          <= '0;
         bus.done     <= 1'b0;
         bus.result   <= '0;
         bus.hi       <= '0;
         bus.div_zero <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  case (bus.sel)
                     SEL_AND, SEL_OR, SEL_SUB, SEL_ADD, SEL_SLT: begin
                        case (bus.sel)
                           SEL_AND: bus.result <= bus.a & bus.b;
                           SEL_OR:  bus.result <= bus.a | bus.b;
                           SEL_SUB: bus.result <= bus.a - bus.b;
                           SEL_ADD: bus.result <= bus.a + bus.b;
                           default: bus.result <= {{(WIDTH-1){1'b0}},
                                                   ($signed(bus.a) < $signed(bus.b))};
                        endcase
                        bus.hi       <= '0;
                        bus.div_zero <= 1'b0;
                        bus.done     <= 1'b1;
                     end
                     SEL_MUL: begin
                        acc   <= '0;
                        mcand <= {{WIDTH{1'b0}}, bus.a};
                        shreg <= bus.b;
                        count <= '0;
                        state <= S_MUL;
                     end
                     SEL_DIV: begin
                        if (bus.b == '0) begin
                           // Divide by zero resolves immediately without iterating.
                           bus.result   <= '1;
                           bus.hi       <= bus.a;
                           bus.div_zero <= 1'b1;
                           bus.done     <= 1'b1;
                        end else begin
                           shreg   <= bus.a;
                           divisor <= bus.b;
                           rem     <= '0;
                           count   <= '0;
                           state   <= S_DIV;
                        end
                     end
                     default: begin
                        // NOP completes but leaves the result registers alone.
                        bus.done <= 1'b1;
                     end
                  endcase
               end
            end
            S_MUL: begin
               acc   <= acc_next;
               mcand <= mcand << 1;
               shreg <= shreg >> 1;
               count <= count + CW'(1);
               if (last_iter) begin
                  bus.result   <= acc_next[WIDTH-1:0];
                  bus.hi       <= acc_next[2*WIDTH-1:WIDTH];
                  bus.div_zero <= 1'b0;
                  bus.done     <= 1'b1;
                  state        <= S_IDLE;
               end
            end
            S_DIV: begin
               rem   <= rem_next;
               shreg <= quot_next;
               count <= count + CW'(1);
               if (last_iter) begin
                  bus.result   <= quot_next;
                  bus.hi       <= rem_next;
                  bus.div_zero <= 1'b0;
                  bus.done     <= 1'b1;
                  state        <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
